regfile_storage: RTL and testbench
==================================

REGFILE_STORAGE -- requirements
Module: regfile_storage

Interface
REQ-001 The block SHALL have parameter DW, default 64, meaning register width in bits.
REQ-002 The block SHALL have parameter AW, default 5, meaning address width; register count NREG = 2**AW = 32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: a write request is presented.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: the block can accept a write this cycle.
REQ-007 The block SHALL have port wr_addr, input, AW bits: the destination register index.
REQ-008 The block SHALL have port wr_data, input, DW bits: the write data, always a full-word write.
REQ-009 The block SHALL have port freeze, input, 1 bit: while high, pending writes are blocked from commit.
REQ-010 The block SHALL have port pend_valid, output, 1 bit: a write is held and not yet committed.
REQ-011 The block SHALL have port pend_addr, output, AW bits: the index of the held write; 0 when pend_valid is low.
REQ-012 The block SHALL have port q, output, [NREG-1:0][DW-1:0]: the full register array, feeding the 64-bit 32:1 read-mux stage directly.

Function
REQ-013 Accept: the block SHALL load a one-entry hold register (addr, data) on a clock edge where wr_valid && wr_ready.
REQ-014 Ready: wr_ready SHALL be combinational and equal to !pend_valid || !freeze.
REQ-015 Commit: on each edge where pend_valid && !freeze, the held data SHALL be written into array[pend_addr].
REQ-016 Decode: the write enable SHALL be one-hot over NREG, and only the addressed register SHALL change.
REQ-017 Latency: data accepted at edge N with freeze low at N+1 SHALL appear on q after edge N+1.
REQ-018 Throughput: with freeze low, one write per cycle SHALL be sustained with no bubbles.
REQ-019 Simultaneous commit and accept on the same edge SHALL commit the old entry and load the new one.
REQ-020 Freeze with an empty hold SHALL accept exactly one write, after which wr_ready drops until freeze falls.
REQ-021 Freeze SHALL NOT alter q; q SHALL change only on a commit.
REQ-022 Back-to-back writes to the same index SHALL commit in order, so the last write wins.
REQ-023 Writes with wr_valid low SHALL have no effect; wr_addr and wr_data are don't-care then.
REQ-024 q SHALL be driven directly from the flops, with no combinational path from wr_* to q.

Reset
REQ-025 On reset assertion, all NREG registers, the hold register, pend_valid and pend_addr SHALL clear to 0 asynchronously.
REQ-026 A write held when reset asserts SHALL be discarded and never committed.
REQ-027 While reset is high, wr_ready SHALL be 1, and no accept or commit SHALL occur.
REQ-028 On the first edge after reset deasserts, a write SHALL be accepted normally.

Configuration
REQ-029 Macro REGFILE_XZR_EN defined: index NREG-1 (X31) SHALL read 0 on q at all times, and commits to it SHALL be discarded.
REQ-030 Under REGFILE_XZR_EN, a write to X31 SHALL still complete the accept/commit handshake normally.
REQ-031 Macro REGFILE_XZR_EN undefined: X31 SHALL be ordinary storage, identical to the other registers.

Structure
REQ-032 Package regfile_pkg SHALL hold the constants DW, AW, NREG and XZR_IDX, and the typedefs reg_word_t and reg_addr_t.
REQ-033 The one-hot write decoder SHALL be a sub-module, dec5to32, taking a 5-bit index and enable and producing a 32-bit one-hot output.
REQ-034 Integration with the downstream read-mux stage SHALL use the default parameters.

Verification
REQ-035 Reset then write addr 5 / 0xDEADBEEF_CAFEF00D with freeze low -> q[5] holds that value after the next edge; all other q are 0.
REQ-036 Write 1..30 on consecutive cycles with freeze low -> wr_ready stays 1 throughout; each q[i] equals its data one edge after accept.
REQ-037 freeze=1, write addr 3 = 0x11, then attempt addr 4 -> wr_ready=0, pend_addr=3, q[3]=0; freeze=0 -> q[3]=0x11, then addr 4 is accepted.
REQ-038 Write addr 31 = 0xFFFF... -> q[31]=0 with REGFILE_XZR_EN defined; q[31]=0xFFFF... without it.
REQ-039 Accept addr 7 = 0x55 under freeze, then pulse reset -> q[7]=0 and pend_valid=0, and the write never appears.
REQ-040 Write addr 9 = 0xA, then addr 9 = 0xB on consecutive cycles -> q[9]=0xA, then 0xB one cycle later.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file storage slice.
package regfile_pkg;

  localparam int DW      = 64;
  localparam int AW      = 5;
  localparam int NREG    = 2 ** AW;
  localparam int XZR_IDX = NREG - 1;

  typedef logic [DW-1:0] reg_word_t;
  typedef logic [AW-1:0] reg_addr_t;

  // Occupancy of the one-entry write hold register.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/regfile_storage_if.sv
// Write request channel into the register file storage.
interface regfile_storage_if #(
  parameter int DW = 64,
  parameter int AW = 5
);

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/regfile_storage_dec5to32.sv
// One-hot write-enable decoder: 5-bit index plus enable to 32 select lines.
module dec5to32 (
  input  logic [4:0]  idx,
  input  logic        en,
  output logic [31:0] onehot
);

  // Exactly one line high when enabled, none otherwise.
  always_comb begin
    onehot      = '0;
    onehot[idx] = en;
  end

endmodule

// File: rtl/regfile_storage.sv
// Register file storage: a one-entry write hold register in front of an
// NREG x DW flop array whose contents drive q directly.
// Optional build macro: REGFILE_XZR_EN makes the top register read as zero.
module regfile_storage #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_storage_if.slave         wr,
  input  logic                     freeze,
  output logic                     pend_valid,
  output logic [AW-1:0]            pend_addr,
  output logic [2**AW-1:0][DW-1:0] q
);

  import regfile_pkg::*;

  localparam int NREG = 2 ** AW;

`ifdef REGFILE_XZR_EN
  localparam bit XZR_EN = 1'b1;
`else
  localparam bit XZR_EN = 1'b0;
`endif

  hold_state_t   state_q, state_d;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;
  logic          accept;
  logic          commit;
  logic [NREG-1:0] we;

  assign pend_valid  = (state_q == HOLD_FULL);
  assign wr.wr_ready = !pend_valid || !freeze;
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign commit      = pend_valid && !freeze;
  assign pend_addr   = pend_valid ? hold_addr : '0;

  // Hold occupancy register; reset discards any held write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= HOLD_EMPTY;
    else       state_q <= state_d;
  end

  // A new accept refills the hold even when the old entry commits on the same edge.
  always_comb begin
    state_d = state_q;
    if (accept)      state_d = HOLD_FULL;
    else if (commit) state_d = HOLD_EMPTY;
  end

  // Capture the accepted write's index and data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_addr <= '0;
      hold_data <= '0;
    end else if (accept) begin
      hold_addr <= wr.wr_addr;
      hold_data <= wr.wr_data;
    end
  end

  dec5to32 u_dec (
    .idx    (hold_addr),
    .en     (commit),
    .onehot (we)
  );

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic [DW-1:0] word_q;

    // Per-register storage; the zero register keeps its flop but only ever loads 0,
    // so its handshake still completes while the data is dropped.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)      word_q <= '0;
      else if (we[i]) word_q <= (XZR_EN && (i == NREG - 1)) ? '0 : hold_data;
    end

    assign q[i] = word_q;
  end

endmodule

// File: tb/tb_regfile_storage.sv
// Directed + randomized bench for regfile_storage against a transaction-level model.
module tb_regfile_storage;

  import regfile_pkg::*;

`ifdef REGFILE_XZR_EN
  localparam bit XZR = 1'b1;
`else
  localparam bit XZR = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     freeze;
  logic                     pend_valid;
  reg_addr_t                pend_addr;
  logic [NREG-1:0][DW-1:0]  q;

  regfile_storage_if #(.DW(DW), .AW(AW)) bus ();

  regfile_storage #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (bus),
    .freeze     (freeze),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .q          (q)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: architectural register contents plus one pending write.
  reg_word_t m_reg [NREG];
  bit        m_pv;
  reg_addr_t m_pa;
  reg_word_t m_pd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_pv = 1'b0;
    m_pa = '0;
    m_pd = '0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREG; i++)
      chk($sformatf("%s q[%0d]", tag, i), q[i], m_reg[i]);
    chk({tag, " pend_valid"}, DW'(pend_valid), DW'(m_pv));
    chk({tag, " pend_addr"}, DW'(pend_addr), m_pv ? DW'(m_pa) : '0);
  endtask

  // Drive one cycle of inputs, check ready before the edge, state after it.
  task automatic cycle(input bit v, input reg_addr_t a, input reg_word_t d, input bit f);
    bit rdy;
    bus.wr_valid = v;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    freeze       = f;
    #1;
    rdy = !m_pv || !f;
    chk("wr_ready", DW'(bus.wr_ready), DW'(rdy));
    @(posedge clk);
    if (m_pv && !f) begin
      if (!(XZR && m_pa == reg_addr_t'(XZR_IDX))) m_reg[m_pa] = m_pd;
      m_pv = 1'b0;
    end
    if (v && rdy) begin
      m_pv = 1'b1;
      m_pa = a;
      m_pd = d;
    end
    #1;
    check_all("post_edge");
  endtask

  // Reset pulse mid-cycle with a write offered under freeze: nothing may happen.
  task automatic reset_pulse();
    #2;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd12;
    bus.wr_data  = 64'h1234;
    freeze       = 1'b1;
    reset        = 1'b1;
    #1;
    model_clear();
    check_all("in_reset");
    chk("ready_in_reset", DW'(bus.wr_ready), 1);
    @(posedge clk);
    #1;
    check_all("reset_edge");
    reset        = 1'b0;
    bus.wr_valid = 1'b0;
    freeze       = 1'b0;
  endtask

  initial begin
    reg_word_t xzr_exp;
    reset        = 1'b1;
    freeze       = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    model_clear();
    #2;
    check_all("reset_state");
    chk("ready_reset", DW'(bus.wr_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First edge after reset accepts; commit lands one edge later.
    cycle(1'b1, 5'd5, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    chk("q5_not_yet", q[5], '0);
    cycle(1'b0, 5'd0, '0, 1'b0);
    chk("q5_written", q[5], 64'hDEAD_BEEF_CAFE_F00D);

    // Streaming writes with no bubbles.
    for (int i = 1; i <= 30; i++)
      cycle(1'b1, reg_addr_t'(i), {$urandom, $urandom}, 1'b0);
    cycle(1'b0, 5'd0, '0, 1'b0);

    // Freeze holds one write and blocks the next.
    reset_pulse();
    cycle(1'b1, 5'd3, 64'h11, 1'b1);
    cycle(1'b1, 5'd4, 64'h44, 1'b1);
    chk("frz_pend_addr", DW'(pend_addr), 3);
    chk("frz_q3", q[3], '0);
    chk("frz_q4", q[4], '0);
    cycle(1'b1, 5'd4, 64'h44, 1'b0);
    chk("unfrz_q3", q[3], 64'h11);
    chk("unfrz_pend4", DW'(pend_addr), 4);
    cycle(1'b0, 5'd0, '0, 1'b0);
    chk("unfrz_q4", q[4], 64'h44);

    // Top register: zero register or ordinary storage depending on build.
    cycle(1'b1, 5'd31, '1, 1'b0);
    cycle(1'b0, 5'd0, '0, 1'b0);
    xzr_exp = XZR ? '0 : '1;
    chk("q31", q[31], xzr_exp);
    chk("q31_pend_clear", DW'(pend_valid), 0);

    // A held write is lost on reset.
    cycle(1'b1, 5'd7, 64'h55, 1'b1);
    chk("held7_pend", DW'(pend_valid), 1);
    reset_pulse();
    chk("rst_q7", q[7], '0);
    chk("rst_pend", DW'(pend_valid), 0);
    cycle(1'b0, 5'd0, '0, 1'b0);
    cycle(1'b0, 5'd0, '0, 1'b0);
    chk("rst_q7_later", q[7], '0);

    // Same-index back-to-back: ordered commit, last wins.
    cycle(1'b1, 5'd9, 64'hA, 1'b0);
    cycle(1'b1, 5'd9, 64'hB, 1'b0);
    chk("q9_first", q[9], 64'hA);
    cycle(1'b0, 5'd0, '0, 1'b0);
    chk("q9_second", q[9], 64'hB);

    // Randomized traffic with random freeze and idle slots.
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 3) != 0, reg_addr_t'($urandom_range(0, NREG - 1)),
            {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    cycle(1'b0, 5'd0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
